// File: rtl/dino_pkg.sv
// Shared constants, FSM encoding and sprite placement helper for the dino frame pipeline.
package dino_pkg;

  localparam int SCREEN_W     = 128;
  localparam int SCREEN_PAGES = 8;
  localparam int FB_BYTES     = 1024;
  localparam int DINO_W       = 16;
  localparam int DINO_H       = 16;
  localparam int OBS_W        = 8;
  localparam int OBS_H        = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPOSE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_READY   = 2'd3
  } state_e;

  typedef enum logic {
    SPR_DINO = 1'b0,
    SPR_OBS  = 1'b1
  } sprite_e;

  // Byte of a 16-row sprite column (bit0 = top) that lands on `page` when its top row is `y`.
  function automatic logic [7:0] place_byte(input logic [15:0] col, input logic [5:0] y,
                                            input logic [2:0] page);
    logic [23:0] sh;
    logic [3:0]  idx;
    sh  = {8'h00, col} << y[2:0];
    idx = {1'b0, page} - {1'b0, y[5:3]};
    case (idx)
      4'd0:    place_byte = sh[7:0];
      4'd1:    place_byte = sh[15:8];
      4'd2:    place_byte = sh[23:16];
      default: place_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// Synchronous 16-bit sprite column ROM (dino 16 columns, obstacle 8 columns), 1-cycle latency.
module sprite_rom
  import dino_pkg::*;
(
  input  logic        clk,
  input  sprite_e     sprite_id,
  input  logic [3:0]  col,
  output logic [15:0] data
);

  localparam int ROM_W = (DINO_H > OBS_H) ? DINO_H : OBS_H;

  logic [ROM_W-1:0] rom_q;

  always_comb begin
    rom_q = '0;
    if (sprite_id == SPR_DINO) begin
      case (col)
        4'd0:  rom_q = 16'h0070;
        4'd1:  rom_q = 16'h00F8;
        4'd2:  rom_q = 16'h01F8;
        4'd3:  rom_q = 16'h03F0;
        4'd4:  rom_q = 16'h0FF0;
        4'd5:  rom_q = 16'hFFE0;
        4'd6:  rom_q = 16'h7FF0;
        4'd7:  rom_q = 16'h1FF8;
        4'd8:  rom_q = 16'h3FFC;
        4'd9:  rom_q = 16'hFFFE;
        4'd10: rom_q = 16'h0FFF;
        4'd11: rom_q = 16'h0FFD;
        4'd12: rom_q = 16'h0FFF;
        4'd13: rom_q = 16'h0EFF;
        4'd14: rom_q = 16'h00BF;
        default: rom_q = 16'h001F;
      endcase
    end else begin
      case (col)
        4'd0:    rom_q = 16'h00F0;
        4'd1:    rom_q = 16'h00F8;
        4'd2:    rom_q = 16'hFFFC;
        4'd3:    rom_q = 16'hFFFF;
        4'd4:    rom_q = 16'hFFFF;
        4'd5:    rom_q = 16'hFFFC;
        4'd6:    rom_q = 16'h3C00;
        4'd7:    rom_q = 16'h3C00;
        default: rom_q = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    data <= rom_q;
  end

endmodule

// File: rtl/frame_composer.sv
// Double-buffered 128x64 frame source: composes ground/dino/obstacle into a back buffer and
// swaps on frameNumber changes. Obstacle merge is built only with FRAME_COMPOSER_OBSTACLE_EN.
module frame_composer
  import dino_pkg::*;
#(
  parameter int DINO_X     = 8,
  parameter int GROUND_ROW = 63,
  parameter int OBS_TOP    = 47
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pixelIndex,
  input  logic [7:0] frameNumber,
  input  logic [5:0] dino_y,
  input  logic [7:0] obs_x,
  output logic [7:0] patternByte,
  output logic       render_busy,
  output logic       frame_valid,
  output logic [7:0] drop_count,
  output logic [1:0] dbg_state
);

  localparam logic [9:0] LAST_ADDR   = 10'(SCREEN_W * SCREEN_PAGES - 1);
  localparam logic [2:0] GROUND_PAGE = 3'(GROUND_ROW >> 3);
  localparam logic [2:0] GROUND_BIT  = 3'(GROUND_ROW & 7);
  localparam logic [5:0] DY_MAX      = 6'd47;

  state_e      state, state_d;
  logic [9:0]  addr;
  logic        drain_cnt;
  logic [7:0]  fn_q;
  logic [5:0]  dy_l;
  logic        front_sel;
  logic        boundary, start, swap, drop;

  logic [8:0]  dino_off;
  logic [15:0] dino_data;
  logic        s1_valid, s1_dino_hit;
  logic [9:0]  s1_addr;
  logic [7:0]  ground_byte, dino_byte, obs_byte;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [7:0]  wr_data;

  logic [7:0]  fb0 [FB_BYTES];
  logic [7:0]  fb1 [FB_BYTES];

  assign boundary    = (frameNumber != fn_q);
  assign render_busy = (state == ST_COMPOSE) || (state == ST_DRAIN);
  assign dbg_state   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    start   = 1'b0;
    swap    = 1'b0;
    drop    = boundary && (state != ST_READY);
    case (state)
      ST_IDLE: begin
        start   = 1'b1;
        state_d = ST_COMPOSE;
      end
      ST_COMPOSE: if (addr == LAST_ADDR) state_d = ST_DRAIN;
      ST_DRAIN:   if (drain_cnt)         state_d = ST_READY;
      ST_READY: begin
        if (boundary) begin
          swap    = 1'b1;
          start   = 1'b1;
          state_d = ST_COMPOSE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fn_q        <= 8'h00;
      addr        <= 10'd0;
      drain_cnt   <= 1'b0;
      dy_l        <= 6'd0;
      front_sel   <= 1'b0;
      frame_valid <= 1'b0;
      drop_count  <= 8'h00;
    end else begin
      fn_q      <= frameNumber;
      drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
      if (start) begin
        addr <= 10'd0;
        dy_l <= (dino_y > DY_MAX) ? DY_MAX : dino_y;
      end else if (state == ST_COMPOSE) begin
        addr <= addr + 10'd1;
      end
      if (swap) begin
        front_sel   <= ~front_sel;
        frame_valid <= 1'b1;
      end
      if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
    end
  end

  // Stage 1: sprite ROM lookups (registered inside the ROM) alongside address and hit flags.
  assign dino_off = {2'b00, addr[6:0]} - 9'(DINO_X);

  sprite_rom u_dino_rom (
    .clk       (clk),
    .sprite_id (SPR_DINO),
    .col       (dino_off[3:0]),
    .data      (dino_data)
  );

`ifdef FRAME_COMPOSER_OBSTACLE_EN
  localparam logic [5:0] OBS_Y = 6'(OBS_TOP);

  logic [7:0]  ox_l;
  logic [8:0]  obs_off;
  logic [15:0] obs_data;
  logic        s1_obs_hit;

  // 9-bit difference: columns left of ox_l go large and miss; col < SCREEN_W bounds the right edge.
  assign obs_off = {2'b00, addr[6:0]} - {1'b0, ox_l};

  sprite_rom u_obs_rom (
    .clk       (clk),
    .sprite_id (SPR_OBS),
    .col       ({1'b0, obs_off[2:0]}),
    .data      (obs_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ox_l       <= 8'h00;
      s1_obs_hit <= 1'b0;
    end else begin
      if (start) ox_l <= obs_x;
      s1_obs_hit <= (obs_off < 9'(OBS_W));
    end
  end

  assign obs_byte = s1_obs_hit ? place_byte(obs_data, OBS_Y, s1_addr[9:7]) : 8'h00;
`else
  logic unused_obs;
  assign unused_obs = ^{obs_x, 6'(OBS_TOP), 4'(OBS_W)};
  assign obs_byte   = 8'h00;
`endif

  assign ground_byte = (s1_addr[9:7] == GROUND_PAGE) ? (8'h01 << GROUND_BIT) : 8'h00;
  assign dino_byte   = s1_dino_hit ? place_byte(dino_data, dy_l, s1_addr[9:7]) : 8'h00;

  // Stage 2: merge registered, written to the back buffer on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_addr     <= 10'd0;
      s1_dino_hit <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= 10'd0;
      wr_data     <= 8'h00;
    end else begin
      s1_valid    <= (state == ST_COMPOSE);
      s1_addr     <= addr;
      s1_dino_hit <= (dino_off < 9'(DINO_W));
      wr_en       <= s1_valid;
      wr_addr     <= s1_addr;
      wr_data     <= ground_byte | dino_byte | obs_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (front_sel) fb0[wr_addr] <= wr_data;
      else           fb1[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    patternByte = 8'h00;
    if (frame_valid) patternByte = front_sel ? fb1[pixelIndex] : fb0[pixelIndex];
  end

endmodule

// File: tb/tb_frame_composer.sv
// Directed bench for frame_composer: swaps, sprite placement, drops and saturation.
module tb_frame_composer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pixelIndex;
  logic [7:0] frameNumber;
  logic [5:0] dino_y;
  logic [7:0] obs_x;
  logic [7:0] patternByte;
  logic       render_busy;
  logic       frame_valid;
  logic [7:0] drop_count;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  int front_dy, front_ox, back_dy, back_ox;

  logic [15:0] dino_col [16] = '{16'h0070, 16'h00F8, 16'h01F8, 16'h03F0, 16'h0FF0, 16'hFFE0,
                                 16'h7FF0, 16'h1FF8, 16'h3FFC, 16'hFFFE, 16'h0FFF, 16'h0FFD,
                                 16'h0FFF, 16'h0EFF, 16'h00BF, 16'h001F};
  logic [15:0] obs_col [8] = '{16'h00F0, 16'h00F8, 16'hFFFC, 16'hFFFF, 16'hFFFF, 16'hFFFC,
                               16'h3C00, 16'h3C00};

  frame_composer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixelIndex  (pixelIndex),
    .frameNumber (frameNumber),
    .dino_y      (dino_y),
    .obs_x       (obs_x),
    .patternByte (patternByte),
    .render_busy (render_busy),
    .frame_valid (frame_valid),
    .drop_count  (drop_count),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  // Pixel-level model: a bit is lit if its row is the ground row or a lit sprite pixel.
  function automatic logic [7:0] exp_byte(input int p, input int c, input int dy, input int ox);
    logic [7:0] b;
    int r;
    b = 8'h00;
    for (int k = 0; k < 8; k++) begin
      r = p * 8 + k;
      if (r == 63) b[k] = 1'b1;
      if (c >= 8 && c < 24 && r >= dy && r < dy + 16 && dino_col[c-8][r-dy]) b[k] = 1'b1;
`ifdef FRAME_COMPOSER_OBSTACLE_EN
      if (c >= ox && c < ox + 8 && r >= 47 && r < 63 && obs_col[c-ox][r-47]) b[k] = 1'b1;
`endif
    end
    return b;
  endfunction

  task automatic read_byte(input int p, input int c, output logic [7:0] v);
    pixelIndex = 10'(p * 128 + c);
    #1;
    v = patternByte;
  endtask

  task automatic scan_frame(input int dy, input int ox, output int bad, output int first,
                            output logic [7:0] got, output logic [7:0] exp);
    logic [7:0] e;
    bad = 0; first = 0; got = 8'h00; exp = 8'h00;
    for (int a = 0; a < 1024; a++) begin
      pixelIndex = 10'(a);
      #1;
      e = exp_byte(a >> 7, a & 127, dy, ox);
      if (patternByte !== e) begin
        if (bad == 0) begin first = a; got = patternByte; exp = e; end
        bad++;
      end
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (dbg_state !== 2'd3 && n < 1200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (dbg_state !== 2'd3) begin
      errors++;
      $display("FAIL wait_ready: state %0d, required 3 within 1200 cycles", dbg_state);
    end
  endtask

  task automatic swap(input logic [7:0] fn, input int ndy, input int nox);
    wait_ready();
    @(negedge clk);
    dino_y = 6'(ndy);
    obs_x = 8'(nox);
    frameNumber = fn;
    @(negedge clk);
    front_dy = back_dy;
    front_ox = back_ox;
    back_dy = (ndy > 47) ? 47 : ndy;
    back_ox = nox;
  endtask

  task automatic test_reset();
    int cnt;
    logic [7:0] v;
    rst_n = 1'b0; frameNumber = 8'd0; dino_y = 6'd47; obs_x = 8'd200; pixelIndex = 10'd0;
    repeat (3) @(negedge clk);
    read_byte(7, 0, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_pattern: got %h, required 00", v); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", frame_valid); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d, required 0", drop_count); end
    checks++; if (render_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", render_busy); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d, required 0", dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (render_busy !== 1'b1) begin errors++; $display("FAIL first_pass_start: busy %b, required 1", render_busy); end
    cnt = (render_busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (dbg_state === 2'd3) break;
      if (render_busy === 1'b1) cnt++;
    end
    checks++; if (cnt !== 1026) begin errors++; $display("FAIL busy_cycles: got %0d, required 1026", cnt); end
    checks++; if (dbg_state !== 2'd3) begin errors++; $display("FAIL ready_after_pass: state %0d, required 3", dbg_state); end
    back_dy = 47; back_ox = 200;
    read_byte(7, 5, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL pre_swap_pattern: got %h, required 00", v); end
  endtask

  task automatic test_first_swap();
    int bad, first, lit;
    logic [7:0] v, g, e;
    swap(8'd1, 3, 124);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL swap_valid: got %b, required 1", frame_valid); end
    checks++; if (render_busy !== 1'b1) begin errors++; $display("FAIL swap_restart: busy %b, required 1", render_busy); end
    lit = 0;
    for (int c = 0; c < 128; c++) begin
      read_byte(7, c, v);
      if (v[7] === 1'b1) lit++;
    end
    checks++; if (lit !== 128) begin errors++; $display("FAIL ground_row: %0d columns lit, required 128", lit); end
    read_byte(6, 13, v);
    checks++; if (v !== 8'hF0) begin errors++; $display("FAIL dino47_p6c13: got %h, required f0", v); end
    read_byte(7, 13, v);
    checks++; if (v !== 8'hFF) begin errors++; $display("FAIL dino47_p7c13: got %h, required ff", v); end
    scan_frame(front_dy, front_ox, bad, first, g, e);
    checks++; if (bad !== 0) begin errors++; $display("FAIL frame_47_200: %0d bad bytes, first addr %0d got %h required %h", bad, first, g, e); end
  endtask

  task automatic test_unaligned();
    int bad, first;
    logic [7:0] v, g, e;
    swap(8'd2, 60, 124);
    read_byte(0, 8, v);
    checks++; if (v !== 8'h80) begin errors++; $display("FAIL dy3_p0c8: got %h, required 80", v); end
    read_byte(1, 8, v);
    checks++; if (v !== 8'h03) begin errors++; $display("FAIL dy3_p1c8: got %h, required 03", v); end
    read_byte(2, 8, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL dy3_p2c8: got %h, required 00", v); end
    read_byte(1, 13, v);
    checks++; if (v !== 8'hFF) begin errors++; $display("FAIL dy3_p1c13: got %h, required ff", v); end
    read_byte(2, 13, v);
    checks++; if (v !== 8'h07) begin errors++; $display("FAIL dy3_p2c13: got %h, required 07", v); end
    scan_frame(front_dy, front_ox, bad, first, g, e);
    checks++; if (bad !== 0) begin errors++; $display("FAIL frame_3_124: %0d bad bytes, first addr %0d got %h required %h", bad, first, g, e); end
  endtask

  task automatic test_obs_edge();
    int bad, first;
    logic [7:0] v, g, e, e124, e127;
`ifdef FRAME_COMPOSER_OBSTACLE_EN
    e124 = 8'h78; e127 = 8'h80;
`else
    e124 = 8'h00; e127 = 8'h00;
`endif
    swap(8'd3, 20, 40);
    read_byte(6, 124, v);
    checks++; if (v !== e124) begin errors++; $display("FAIL obs_p6c124: got %h, required %h", v, e124); end
    read_byte(5, 127, v);
    checks++; if (v !== e127) begin errors++; $display("FAIL obs_p5c127: got %h, required %h", v, e127); end
    read_byte(7, 0, v);
    checks++; if (v !== 8'h80) begin errors++; $display("FAIL obs_nowrap_p7c0: got %h, required 80", v); end
    read_byte(6, 0, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL obs_nowrap_p6c0: got %h, required 00", v); end
    read_byte(6, 123, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL obs_p6c123: got %h, required 00", v); end
    read_byte(7, 13, v);
    checks++; if (v !== 8'hFF) begin errors++; $display("FAIL clamp_p7c13: got %h, required ff", v); end
    scan_frame(front_dy, front_ox, bad, first, g, e);
    checks++; if (bad !== 0) begin errors++; $display("FAIL frame_47_124: %0d bad bytes, first addr %0d got %h required %h", bad, first, g, e); end
  endtask

  task automatic test_obs_off();
    int bad, first;
    logic [7:0] v, acc, g, e, exp_acc;
`ifdef FRAME_COMPOSER_OBSTACLE_EN
    exp_acc = 8'hFF;
`else
    exp_acc = 8'h00;
`endif
    swap(8'd4, 10, 0);
    acc = 8'h00;
    for (int c = 40; c < 48; c++) begin
      for (int p = 5; p < 7; p++) begin
        read_byte(p, c, v);
        acc = acc | v;
      end
    end
    checks++; if (acc !== exp_acc) begin errors++; $display("FAIL obs40_pages56: OR of bytes %h, required %h", acc, exp_acc); end
    scan_frame(front_dy, front_ox, bad, first, g, e);
    checks++; if (bad !== 0) begin errors++; $display("FAIL frame_20_40: %0d bad bytes, first addr %0d got %h required %h", bad, first, g, e); end
  endtask

  task automatic test_drop();
    int bad, first;
    logic [7:0] v, g, e;
    repeat (498) @(negedge clk);
    frameNumber = 8'd5;
    @(negedge clk);
    checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL drop_count_1: got %0d, required 1", drop_count); end
    checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL drop_keeps_compose: state %0d, required 1", dbg_state); end
    read_byte(3, 13, v);
    checks++; if (v !== 8'hFE) begin errors++; $display("FAIL drop_no_swap: got %h, required fe", v); end
    wait_ready();
    checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL drop_count_ready: got %0d, required 1", drop_count); end
    swap(8'd0, 5, 100);
    read_byte(2, 13, v);
    checks++; if (v !== 8'hFF) begin errors++; $display("FAIL swap_after_drop: got %h, required ff", v); end
    scan_frame(front_dy, front_ox, bad, first, g, e);
    checks++; if (bad !== 0) begin errors++; $display("FAIL frame_10_0: %0d bad bytes, first addr %0d got %h required %h", bad, first, g, e); end
  endtask

  task automatic test_game_start();
    int bad, first;
    logic [7:0] v, g, e;
    wait_ready();
    @(negedge clk);
    dino_y = 6'd30; obs_x = 8'd60; frameNumber = 8'd7;
    @(negedge clk);
    frameNumber = 8'd0;
    front_dy = back_dy; front_ox = back_ox; back_dy = 30; back_ox = 60;
    @(negedge clk);
    checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL game_start_drop: got %0d, required 2", drop_count); end
    checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL game_start_state: got %0d, required 1", dbg_state); end
    read_byte(1, 13, v);
    checks++; if (v !== 8'hFC) begin errors++; $display("FAIL game_start_swap: got %h, required fc", v); end
    scan_frame(front_dy, front_ox, bad, first, g, e);
    checks++; if (bad !== 0) begin errors++; $display("FAIL frame_5_100: %0d bad bytes, first addr %0d got %h required %h", bad, first, g, e); end
  endtask

  task automatic test_saturate();
    int bad, first;
    logic [7:0] v, g, e;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      frameNumber = (i % 2 == 0) ? 8'd2 : 8'd1;
    end
    @(negedge clk);
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_saturate: got %0d, required 255", drop_count); end
    checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL saturate_state: got %0d, required 1", dbg_state); end
    swap(8'd9, 47, 200);
    read_byte(4, 13, v);
    checks++; if (v !== 8'hF8) begin errors++; $display("FAIL dy30_p4c13: got %h, required f8", v); end
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_hold: got %0d, required 255", drop_count); end
    scan_frame(front_dy, front_ox, bad, first, g, e);
    checks++; if (bad !== 0) begin errors++; $display("FAIL frame_30_60: %0d bad bytes, first addr %0d got %h required %h", bad, first, g, e); end
  endtask

  initial begin
    test_reset();
    test_first_swap();
    test_unaligned();
    test_obs_edge();
    test_obs_off();
    test_drop();
    test_game_start();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
